ifft_r4_butterfly_seq: RTL and testbench
========================================

# ifft_r4_butterfly_seq

Sequential radix-4 inverse butterfly for the 16-point FFT datapath, the inverse-direction counterpart of the forward radix-4 butterfly. It accepts four complex samples (A, B, C, D) one per handshake, computes the 4-point inverse DFT with the +j rotation in place of -j, and streams four complex results out under valid/ready flow control. It sits in the IFFT path, between the stage reorder buffer and the next stage or the output formatter.

## Interface
- No parameters; data width is fixed at 16-bit signed real and imag.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_re, in_im  in  16 each  signed input sample, order A, B, C, D
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_re, out_im  out  16 each  signed result, order y0, y1, y2, y3
- out_last  out  1  high with y3

## Operation
- One clock; reset is asynchronous and active-low.
- States: LOAD, CALC, DRAIN. Reset enters LOAD with sample counter = 0.
- LOAD: in_ready = 1. Each cycle with in_valid && in_ready stores the sample in slot[cnt] and increments cnt. Accepting slot 3 moves to CALC and wraps cnt to 0.
- CALC: one cycle, in_ready = 0. Computes all results at 18-bit width and registers them. Moves to DRAIN.
- DRAIN: out_valid = 1, and result[cnt] is presented. Each out_valid && out_ready advances cnt. Accepting y3 returns to LOAD.
- Equations (sign-extend all terms to 18 bits):
  - y0 = A+B+C+D
  - y1r = Ar-Bi-Cr+Di; y1i = Ai+Br-Ci-Dr
  - y2 = A-B+C-D (real and imag independently)
  - y3r = Ar+Bi-Cr-Di; y3i = Ai-Br-Ci+Dr
- Output narrowing to 16 bits is set by the Configuration macro.
- out_last = out_valid && (cnt == 3).
- No overlap: new input is not accepted until y3 is accepted.

## Timing
- Reset values: in_ready = 0 during reset and 1 in the first cycle after deassertion. out_valid = 0, out_last = 0, out_re = 0, out_im = 0. Slots and counter are cleared.
- Latency: 4th input accepted at edge k. CALC occupies cycle k..k+1. out_valid rises after edge k+1, and y0 is presented in the following cycle.
- Full-rate throughput: 4 in-cycles + 1 CALC + 4 out-cycles = 9 cycles per butterfly.
- Backpressure: while out_valid && !out_ready, out_re, out_im and out_last hold stable. out_valid never drops before acceptance.
- in_valid is ignored in CALC and DRAIN. Samples presented then are not consumed and are not lost from the upstream view, since in_ready = 0.
- Reset asserted in any state returns to LOAD immediately. Partially loaded samples and undelivered results are discarded, and out_valid drops asynchronously.
- Gaps in in_valid during LOAD are allowed. The counter holds and the partial group is kept.

## Configuration
- IFFT_SCALE_EN defined:
  - Each 18-bit result is arithmetic-shifted right by 2 (floor) and the low 16 bits are output.
  - This gives the 1/4 inverse normalisation and cannot overflow.
- Undefined:
  - The low 16 bits of the 18-bit result are output, with two's-complement wrap.
  - This matches forward butterfly arithmetic.

## Test plan
- Impulse: A = (100,0), B = C = D = 0 -> y0..y3 all (100,0) unscaled; all (25,0) with IFFT_SCALE_EN. out_last only on y3.
- Rotation direction: B = (1000,0), others 0 -> y0 = (1000,0), y1 = (0,1000), y2 = (-1000,0), y3 = (0,-1000). With IFFT_SCALE_EN: (250,0), (0,250), (-250,0), (0,-250).
- Overflow: A = B = C = D = (16000,-16000) -> y0 unscaled = (-1536,1536) by wrap; with IFFT_SCALE_EN y0 = (16000,-16000). y1, y2, y3 = (0,0) in both.
- Backpressure and gaps: in_valid toggles 1,0,1,1,0,1. out_ready is held low for 5 cycles after out_valid rises, then toggles. Required: exactly 4 outputs in order, each held stable while stalled, and in_ready = 0 throughout CALC and DRAIN.
- Reset mid-operation: assert rst_n = 0 after 2 inputs are loaded, and again in DRAIN after y1. Required: out_valid = 0 immediately. After release, a fresh A..D group produces correct results with no leftover data.
- Back-to-back: two groups streamed with in_valid and out_ready held at 1. Required: 9-cycle period, and the second group's outputs are independent of the first.

Source files
------------

// File: rtl/ifft_r4_butterfly_seq.sv
// ifft_r4_butterfly_seq: sequential radix-4 inverse butterfly (+j rotation), 4 samples in, 4 results out.
// Optional IFFT_SCALE_EN: results are scaled by 1/4 (arithmetic shift) instead of wrapped.
`default_nettype none

module ifft_r4_butterfly_seq (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_re,
  input  logic signed [15:0] in_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_re,
  output logic signed [15:0] out_im,
  output logic               out_last
);

`ifdef IFFT_SCALE_EN
  localparam int c_SHIFT = 2;
`else
  localparam int c_SHIFT = 0;
`endif

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_cnt;
  logic signed [15:0] r_slot_re [4];
  logic signed [15:0] r_slot_im [4];
  logic signed [15:0] r_res_re  [4];
  logic signed [15:0] r_res_im  [4];
  logic               w_acc_in;
  logic               w_acc_out;

  logic signed [17:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
  logic signed [17:0] w_y_re [4];
  logic signed [17:0] w_y_im [4];

  assign w_ar = {{2{r_slot_re[0][15]}}, r_slot_re[0]};
  assign w_ai = {{2{r_slot_im[0][15]}}, r_slot_im[0]};
  assign w_br = {{2{r_slot_re[1][15]}}, r_slot_re[1]};
  assign w_bi = {{2{r_slot_im[1][15]}}, r_slot_im[1]};
  assign w_cr = {{2{r_slot_re[2][15]}}, r_slot_re[2]};
  assign w_ci = {{2{r_slot_im[2][15]}}, r_slot_im[2]};
  assign w_dr = {{2{r_slot_re[3][15]}}, r_slot_re[3]};
  assign w_di = {{2{r_slot_im[3][15]}}, r_slot_im[3]};

  // Inverse twiddles: B, C, D are rotated by +j^k, j^2k, j^3k for output k.
  assign w_y_re[0] = w_ar + w_br + w_cr + w_dr;
  assign w_y_im[0] = w_ai + w_bi + w_ci + w_di;
  assign w_y_re[1] = w_ar - w_bi - w_cr + w_di;
  assign w_y_im[1] = w_ai + w_br - w_ci - w_dr;
  assign w_y_re[2] = w_ar - w_br + w_cr - w_dr;
  assign w_y_im[2] = w_ai - w_bi + w_ci - w_di;
  assign w_y_re[3] = w_ar + w_bi - w_cr - w_di;
  assign w_y_im[3] = w_ai - w_br - w_ci + w_dr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_acc_in  = 1'b0;
    w_acc_out = 1'b0;
    case (r_state)
      LOAD: begin
        // Reset is folded in so upstream never sees ready while held in reset.
        in_ready = rst_n;
        w_acc_in = in_valid;
        if (in_valid && (r_cnt == 2'd3)) w_next = CALC;
      end
      CALC: begin
        w_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        w_acc_out = out_ready;
        if (out_ready && (r_cnt == 2'd3)) w_next = LOAD;
      end
      default: begin
        w_next = LOAD;
      end
    endcase
    out_re   = out_valid ? r_res_re[r_cnt] : '0;
    out_im   = out_valid ? r_res_im[r_cnt] : '0;
    out_last = out_valid && (r_cnt == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        r_slot_re[i] <= '0;
        r_slot_im[i] <= '0;
        r_res_re[i]  <= '0;
        r_res_im[i]  <= '0;
      end
    end else begin
      if (w_acc_in) begin
        r_slot_re[r_cnt] <= in_re;
        r_slot_im[r_cnt] <= in_im;
      end
      if (w_acc_in || w_acc_out) r_cnt <= r_cnt + 2'd1;
      if (r_state == CALC) begin
        for (int i = 0; i < 4; i++) begin
          r_res_re[i] <= 16'(w_y_re[i] >>> c_SHIFT);
          r_res_im[i] <= 16'(w_y_im[i] >>> c_SHIFT);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifft_r4_butterfly_seq.sv
// Self-checking bench for ifft_r4_butterfly_seq against a 4-point inverse DFT reference model.
`default_nettype none

module tb_ifft_r4_butterfly_seq;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic               in_ready;
  logic               out_valid;
  logic               out_last;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;

  int n_assert = 0;
  int n_fail   = 0;

  int                 src_re[$];
  int                 src_im[$];
  logic signed [15:0] exp_re[$];
  logic signed [15:0] exp_im[$];
  int                 lat_q[$];
  int                 rise_cyc[$];
  int                 grp_re[4];
  int                 grp_im[4];
  int                 grp_n;

  ifft_r4_butterfly_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic signed [15:0] narrow(input int v);
    int t;
    t = v;
`ifdef IFFT_SCALE_EN
    t = t >>> 2;
`endif
    return t[15:0];
  endfunction

  // y[k] = sum_n x[n] * (+j)^(n*k), exact integer arithmetic
  function automatic void model_push();
    for (int k = 0; k < 4; k++) begin
      int sr, si;
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin sr += grp_re[n]; si += grp_im[n]; end
          1: begin sr -= grp_im[n]; si += grp_re[n]; end
          2: begin sr -= grp_re[n]; si -= grp_im[n]; end
          default: begin sr += grp_im[n]; si -= grp_re[n]; end
        endcase
      end
      exp_re.push_back(narrow(sr));
      exp_im.push_back(narrow(si));
    end
  endfunction

  task automatic push_sample(input int re, input int im);
    src_re.push_back(re);
    src_im.push_back(im);
  endtask

  task automatic push_rand(input int n);
    logic signed [15:0] r, i;
    for (int s = 0; s < n; s++) begin
      r = 16'($urandom);
      i = 16'($urandom);
      src_re.push_back(r);
      src_im.push_back(i);
    end
  endtask

  // gap_mode/stall_mode: 0 = always on, 1 = directed pattern, 2 = random.
  // Stops when all queued samples are consumed and all expected results drained,
  // or after abort_after outputs (abort_after < 0 disables).
  task automatic run_stream(input int gap_mode, input int stall_mode, input int abort_after);
    int  cyc, pat_i, ov_cnt, n_out;
    bit  calc_chk, prev_ov, acc_in, acc_out, timed_out;
    int  gap_pat[6];
    gap_pat = '{1, 0, 1, 1, 0, 1};
    cyc = 0; pat_i = 0; ov_cnt = 0; n_out = 0;
    calc_chk = 0; prev_ov = 0; timed_out = 1;
    grp_n = 0;
    exp_re.delete(); exp_im.delete(); lat_q.delete(); rise_cyc.delete();
    while (cyc < 2000) begin
      if (src_re.size() == 0 && exp_re.size() == 0) begin timed_out = 0; break; end
      if (abort_after >= 0 && n_out == abort_after) begin timed_out = 0; break; end
      if (src_re.size() > 0) begin
        case (gap_mode)
          0:       in_valid = 1'b1;
          1:       in_valid = gap_pat[pat_i % 6] != 0;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        in_re = 16'(src_re[0]);
        in_im = 16'(src_im[0]);
      end else begin
        in_valid = 1'b0;
      end
      case (stall_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ov_cnt >= 5) && (((ov_cnt - 5) % 2) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (calc_chk) begin
        check("calc_in_ready", 32'(in_ready), 0);
        check("calc_out_valid", 32'(out_valid), 0);
        calc_chk = 0;
      end
      if (out_valid && !prev_ov) begin
        rise_cyc.push_back(cyc);
        if (lat_q.size() > 0) check("latency", cyc, lat_q.pop_front());
        else check("spurious_valid", 32'(out_valid), 0);
      end
      if (out_valid) begin
        check("drain_in_ready", 32'(in_ready), 0);
        if (exp_re.size() > 0) begin
          check("out_re", 32'(out_re), 32'(exp_re[0]));
          check("out_im", 32'(out_im), 32'(exp_im[0]));
          check("out_last", 32'(out_last), 32'((n_out % 4) == 3));
        end else begin
          check("extra_output", 32'(out_valid), 0);
        end
      end else begin
        check("idle_last", 32'(out_last), 0);
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      prev_ov = out_valid;
      if (out_valid) ov_cnt++; else ov_cnt = 0;
      @(posedge clk); #1;
      cyc++;
      if (src_re.size() > 0) pat_i++;
      if (acc_in) begin
        grp_re[grp_n] = src_re.pop_front();
        grp_im[grp_n] = src_im.pop_front();
        grp_n++;
        if (grp_n == 4) begin
          model_push();
          grp_n = 0;
          lat_q.push_back(cyc + 1);
          calc_chk = 1;
        end
      end
      if (acc_out) begin
        void'(exp_re.pop_front());
        void'(exp_im.pop_front());
        n_out++;
      end
    end
    check("stream_done", 32'(timed_out), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_out_re"}, 32'(out_re), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check({tag, "_ready_after"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_re", 32'(out_re), 0);
    check("rst_out_im", 32'(out_im), 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(in_ready), 1);

    // Impulse
    push_sample(100, 0); push_sample(0, 0); push_sample(0, 0); push_sample(0, 0);
    run_stream(0, 0, -1);

    // Rotation direction
    push_sample(0, 0); push_sample(1000, 0); push_sample(0, 0); push_sample(0, 0);
    run_stream(0, 0, -1);

    // Overflow / wrap
    for (int i = 0; i < 4; i++) push_sample(16000, -16000);
    run_stream(0, 0, -1);

    // Backpressure and input gaps
    push_rand(4);
    run_stream(1, 1, -1);

    // Reset after two inputs loaded, then a fresh group
    push_rand(2);
    run_stream(0, 0, -1);
    pulse_reset("rst_load");
    push_rand(4);
    run_stream(0, 0, -1);

    // Reset in DRAIN after y1 accepted, then a fresh group
    push_rand(4);
    run_stream(0, 0, 2);
    pulse_reset("rst_drain");
    push_rand(4);
    run_stream(0, 1, -1);

    // Back-to-back at full rate
    push_rand(8);
    run_stream(0, 0, -1);
    check("b2b_rises", rise_cyc.size(), 2);
    if (rise_cyc.size() >= 2) check("b2b_period", rise_cyc[1] - rise_cyc[0], 9);

    // Random traffic with random gaps and stalls
    for (int g = 0; g < 6; g++) begin
      push_rand(4 * (1 + (g % 2)));
      run_stream(2, 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
